// File: rtl/lcd_bus_receiver_if.sv
// Character-LCD bus (4-bit HD44780 style) between a display driver and a receiver.
interface lcd_bus_receiver_if;
    logic sf_e;
    logic e;
    logic rs;
    logic rw;
    logic d;
    logic c;
    logic b;
    logic a;

    modport master (output sf_e, e, rs, rw, d, c, b, a);
    modport slave  (input  sf_e, e, rs, rw, d, c, b, a);
endinterface

// File: rtl/lcd_bus_receiver.sv
// Passive LCD bus monitor: strobe sampling, nibble assembly, command decode and a
// 2x16 shadow of display RAM readable through a registered port.
module lcd_bus_receiver #(
    parameter int unsigned CLR_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_receiver_if.slave bus,
    input  logic [4:0]        rd_addr,
    output logic [7:0]        rd_char,
    output logic              byte_valid,
    output logic              byte_rs,
    output logic [7:0]        byte_data,
    output logic [6:0]        ddram_addr,
    output logic              mode_4bit,
    output logic              disp_on,
    output logic              busy,
    output logic              err
);
    localparam int unsigned CntW = $clog2(CLR_CYCLES + 1);

    typedef enum logic {PhHigh, PhLow} phase_e;

    // Stage 1: strobe capture
    logic       e_q, stb_q, rs_q, rw_q;
    logic [3:0] nib_q;

    // Stage 2: assembly, decode and state
    phase_e          phase_q, phase_d;
    logic [3:0]      hi_nib_q, hi_nib_d;
    logic            hi_rs_q, hi_rs_d;
    logic            byte_valid_q, byte_valid_d;
    logic            byte_rs_q, byte_rs_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic [6:0]      addr_q, addr_d;
    logic            incr_q, incr_d;
    logic            mode_4bit_q, mode_4bit_d;
    logic            disp_on_q, disp_on_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [CntW-1:0] clr_cnt_q, clr_cnt_d;

    logic [7:0] shadow_q [32];
    logic [7:0] rd_char_q;

    logic       asm_ok;
    logic [7:0] asm_byte;
    logic       sh_we;
    logic [4:0] sh_idx;
    logic [7:0] sh_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= 1'b0;
            stb_q <= 1'b0;
            rs_q  <= 1'b0;
            rw_q  <= 1'b0;
            nib_q <= 4'h0;
        end else begin
            e_q   <= bus.e;
            stb_q <= e_q & ~bus.e & bus.sf_e;
            if (e_q && !bus.e && bus.sf_e) begin
                nib_q <= {bus.d, bus.c, bus.b, bus.a};
                rs_q  <= bus.rs;
                rw_q  <= bus.rw;
            end
        end
    end

    always_comb begin
        phase_d      = phase_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        byte_valid_d = 1'b0;
        byte_rs_d    = byte_rs_q;
        byte_data_d  = byte_data_q;
        addr_d       = addr_q;
        incr_d       = incr_q;
        mode_4bit_d  = mode_4bit_q;
        disp_on_d    = disp_on_q;
        busy_d       = busy_q;
        err_d        = 1'b0;
        clr_cnt_d    = clr_cnt_q;
        asm_ok       = 1'b0;
        asm_byte     = 8'h00;
        sh_we        = 1'b0;
        sh_idx       = clr_cnt_q[4:0];
        sh_wdata     = 8'h20;

        if (busy_q) begin
            if (clr_cnt_q < CntW'(32)) begin
                sh_we = 1'b1;
            end
            clr_cnt_d = clr_cnt_q + CntW'(1);
            if (clr_cnt_q == CntW'(CLR_CYCLES - 1)) begin
                busy_d = 1'b0;
            end
        end

        if (stb_q) begin
            if (rw_q) begin
                err_d   = 1'b1;
                phase_d = PhHigh;
            end else if (!mode_4bit_q) begin
                asm_ok   = 1'b1;
                asm_byte = {nib_q, 4'h0};
            end else if (phase_q == PhHigh) begin
                hi_nib_d = nib_q;
                hi_rs_d  = rs_q;
                phase_d  = PhLow;
            end else begin
                phase_d = PhHigh;
                if (rs_q != hi_rs_q) begin
                    err_d = 1'b1;
                end else begin
                    asm_ok   = 1'b1;
                    asm_byte = {hi_nib_q, nib_q};
                end
            end
        end

        if (asm_ok && !rs_q) begin
            byte_valid_d = 1'b1;
            byte_rs_d    = 1'b0;
            byte_data_d  = asm_byte;
            if (asm_byte[7:5] == 3'b001) begin
                mode_4bit_d = ~asm_byte[4];
                phase_d     = PhHigh;
            end
            if (asm_byte == 8'h01) begin
                addr_d    = 7'h00;
                incr_d    = 1'b1;
                busy_d    = 1'b1;
                clr_cnt_d = '0;
            end else if (asm_byte[7:1] == 7'b0000001) begin
                addr_d = 7'h00;
            end else if (asm_byte[7:2] == 6'b000001) begin
                incr_d = asm_byte[1];
            end else if (asm_byte[7:3] == 5'b00001) begin
                disp_on_d = asm_byte[2];
            end else if (asm_byte[7]) begin
                addr_d = asm_byte[6:0];
            end
        end else if (asm_ok) begin
            // A data byte during clear is reported only as an error so err and
            // byte_valid stay mutually exclusive; the address still advances.
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                byte_valid_d = 1'b1;
                byte_rs_d    = 1'b1;
                byte_data_d  = asm_byte;
                if (addr_q[6:4] == 3'b000 || addr_q[6:4] == 3'b100) begin
                    sh_we    = 1'b1;
                    sh_idx   = {addr_q[6], addr_q[3:0]};
                    sh_wdata = asm_byte;
                end
            end
            addr_d = incr_q ? addr_q + 7'd1 : addr_q - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PhHigh;
            hi_nib_q     <= 4'h0;
            hi_rs_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= 8'h00;
            addr_q       <= 7'h00;
            incr_q       <= 1'b1;
            mode_4bit_q  <= 1'b0;
            disp_on_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            clr_cnt_q    <= '0;
        end else begin
            phase_q      <= phase_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            byte_valid_q <= byte_valid_d;
            byte_rs_q    <= byte_rs_d;
            byte_data_q  <= byte_data_d;
            addr_q       <= addr_d;
            incr_q       <= incr_d;
            mode_4bit_q  <= mode_4bit_d;
            disp_on_q    <= disp_on_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= 8'h20;
            end
            rd_char_q <= 8'h20;
        end else begin
            if (sh_we) begin
                shadow_q[sh_idx] <= sh_wdata;
            end
            rd_char_q <= shadow_q[rd_addr];
        end
    end

    assign rd_char    = rd_char_q;
    assign byte_valid = byte_valid_q;
    assign byte_rs    = byte_rs_q;
    assign byte_data  = byte_data_q;
    assign ddram_addr = addr_q;
    assign mode_4bit  = mode_4bit_q;
    assign disp_on    = disp_on_q;
    assign busy       = busy_q;
    assign err        = err_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with a byte-level reference model and per-cycle compare.
module tb_lcd_bus_receiver;
    localparam int ClrCycles = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       byte_valid, byte_rs;
    logic [7:0] byte_data;
    logic [6:0] ddram_addr;
    logic       mode_4bit, disp_on, busy, err;

    lcd_bus_receiver_if bus ();

    lcd_bus_receiver #(.CLR_CYCLES(ClrCycles)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .rd_addr   (rd_addr),
        .rd_char   (rd_char),
        .byte_valid(byte_valid),
        .byte_rs   (byte_rs),
        .byte_data (byte_data),
        .ddram_addr(ddram_addr),
        .mode_4bit (mode_4bit),
        .disp_on   (disp_on),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: what the LCD bus has said so far, tracked per byte.
    int         m_addr, busy_left;
    bit         m_inc, m_4bit, m_disp, m_bv, m_err, m_brs, busy_now;
    bit         m_have_hi, m_hi_rs;
    logic [3:0] m_hi;
    logic [7:0] m_bdata;
    logic [7:0] shadow_m [32];
    bit         chk_en = 0;
    int         bv_count = 0, err_count = 0, busy_cycles = 0;

    task automatic model_reset();
        m_addr = 0; m_inc = 1; m_4bit = 0; m_disp = 0; m_bv = 0; m_err = 0;
        m_brs = 0; m_bdata = 8'h00; m_have_hi = 0; m_hi_rs = 0; m_hi = 4'h0;
        busy_left = 0; busy_now = 0;
        for (int i = 0; i < 32; i++) shadow_m[i] = 8'h20;
    endtask

    task automatic model_byte(input logic [7:0] by, input bit rs_v);
        int v;
        v = int'(by);
        if (!rs_v) begin
            m_bv = 1; m_brs = 0; m_bdata = by;
            if (v >= 32 && v <= 63) begin
                m_4bit = (v < 48);
                m_have_hi = 0;
            end
            if (v == 1) begin
                m_addr = 0; m_inc = 1; busy_left = ClrCycles;
                for (int i = 0; i < 32; i++) shadow_m[i] = 8'h20;
            end else if (v == 2 || v == 3) m_addr = 0;
            else if (v >= 4 && v <= 7) m_inc = (v % 4) >= 2;
            else if (v >= 8 && v <= 15) m_disp = (v % 8) >= 4;
            else if (v >= 128) m_addr = v - 128;
        end else begin
            if (busy_now) m_err = 1;
            else begin
                m_bv = 1; m_brs = 1; m_bdata = by;
                if (m_addr < 16) shadow_m[m_addr] = by;
                else if (m_addr >= 64 && m_addr < 80) shadow_m[m_addr - 48] = by;
            end
            m_addr = m_inc ? (m_addr + 1) % 128 : (m_addr + 127) % 128;
        end
    endtask

    task automatic model_strobe(input logic [3:0] nib, input bit rs_v, input bit rw_v);
        if (rw_v) begin
            m_err = 1; m_have_hi = 0;
        end else if (!m_4bit) begin
            model_byte({nib, 4'h0}, rs_v);
        end else if (!m_have_hi) begin
            m_hi = nib; m_hi_rs = rs_v; m_have_hi = 1;
        end else begin
            m_have_hi = 0;
            if (rs_v != m_hi_rs) m_err = 1;
            else model_byte({m_hi, nib}, rs_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byte_valid", byte_valid, m_bv);
            chk("err", err, m_err);
            chk("err_bv_exclusive", err & byte_valid, 0);
            chk("byte_rs", byte_rs, m_brs);
            chk("byte_data", byte_data, m_bdata);
            chk("ddram_addr", ddram_addr, m_addr);
            chk("mode_4bit", mode_4bit, m_4bit);
            chk("disp_on", disp_on, m_disp);
            busy_now = busy_left > 0;
            chk("busy", busy, busy_now);
            if (busy_left > 0) busy_left--;
            if (byte_valid) bv_count++;
            if (err) err_count++;
            if (busy) busy_cycles++;
        end
    end

    // All tasks are entered and left 2 time units after a rising edge.
    task automatic strobe(input logic [3:0] nib, input bit rs_v, input bit rw_v, input bit sf_v);
        {bus.d, bus.c, bus.b, bus.a} = nib;
        bus.rs = rs_v; bus.rw = rw_v; bus.sf_e = sf_v; bus.e = 1'b1;
        @(posedge clk); #2 bus.e = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        if (sf_v) model_strobe(nib, rs_v, rw_v);
        @(posedge clk); #1;
        m_bv = 0; m_err = 0;
        #1 bus.sf_e = 1'b1;
    endtask

    task automatic send4(input logic [7:0] by, input bit rs_v);
        strobe(by[7:4], rs_v, 1'b0, 1'b1);
        strobe(by[3:0], rs_v, 1'b0, 1'b1);
    endtask

    task automatic check_rd(input int idx);
        rd_addr = 5'(idx);
        @(posedge clk); #2;
        chk("rd_char", rd_char, shadow_m[idx]);
    endtask

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        chk("clear_finishes", busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (4) begin
            @(posedge clk); #2 bus.e = ~bus.e;
        end
        bus.e = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bv0, err0;
        rst_n = 1'b1; rd_addr = 5'd0;
        bus.sf_e = 1'b1; bus.e = 1'b0; bus.rs = 1'b0; bus.rw = 1'b0;
        {bus.d, bus.c, bus.b, bus.a} = 4'h0;
        #1 rst_n = 1'b0;
        model_reset();
        chk_en = 1;

        // Reset held with e toggling: every read index shows a blank.
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            bus.e = ~bus.e;
            @(posedge clk); #2;
            chk("reset_rd_char", rd_char, 8'h20);
        end
        chk("reset_ddram_addr", ddram_addr, 0);
        bus.e = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) check_rd(i);

        // 8-bit init sequence ending in a switch to 4-bit mode.
        bv0 = bv_count;
        strobe(4'h3, 1'b0, 1'b0, 1'b1);
        strobe(4'h3, 1'b0, 1'b0, 1'b1);
        strobe(4'h3, 1'b0, 1'b0, 1'b1);
        strobe(4'h2, 1'b0, 1'b0, 1'b1);
        chk("init_bv_count", bv_count - bv0, 4);
        chk("init_last_byte", byte_data, 8'h20);
        chk("init_mode_4bit", mode_4bit, 1);

        // 4-bit writes: display on, line 2 start, one character.
        rd_addr = 5'd16;
        send4(8'h28, 1'b0);
        send4(8'h0C, 1'b0);
        send4(8'hC0, 1'b0);
        send4(8'h41, 1'b1);
        chk("write_disp_on", disp_on, 1);
        chk("write_ddram_addr", ddram_addr, 7'h41);
        chk("write_rd_char16", rd_char, 8'h41);

        // Clear after a write at the end of line 1.
        send4(8'h8F, 1'b0);
        send4(8'h42, 1'b1);
        check_rd(15);
        chk("pre_clear_rd15", rd_char, 8'h42);
        busy_cycles = 0;
        send4(8'h01, 1'b0);
        wait_not_busy();
        chk("clear_busy_cycles", busy_cycles, 32);
        chk("clear_ddram_addr", ddram_addr, 0);
        check_rd(15);
        chk("clear_rd15", rd_char, 8'h20);

        // Data during a clear is rejected but the address still moves.
        err0 = err_count;
        send4(8'h01, 1'b0);
        send4(8'h55, 1'b1);
        chk("busy_data_err", err_count - err0, 1);
        wait_not_busy();
        chk("busy_data_addr", ddram_addr, 7'h01);
        check_rd(0);
        chk("busy_data_dropped", rd_char, 8'h20);

        // Protocol errors and ignored strobes.
        bv0 = bv_count; err0 = err_count;
        strobe(4'h5, 1'b0, 1'b1, 1'b1);
        chk("rw_err", err_count - err0, 1);
        chk("rw_no_byte", bv_count - bv0, 0);
        strobe(4'h0, 1'b0, 1'b0, 1'b1);
        strobe(4'h8, 1'b1, 1'b0, 1'b1);
        chk("rs_mismatch_err", err_count - err0, 2);
        chk("rs_mismatch_no_byte", bv_count - bv0, 0);
        send4(8'h08, 1'b0);
        chk("phase_resync_disp_off", disp_on, 0);
        bv0 = bv_count; err0 = err_count;
        strobe(4'h8, 1'b0, 1'b0, 1'b0);
        strobe(4'h0, 1'b0, 1'b0, 1'b0);
        chk("sf_e_low_no_byte", bv_count - bv0, 0);
        chk("sf_e_low_no_err", err_count - err0, 0);

        // Address wrap in both directions.
        send4(8'h04, 1'b0);
        send4(8'h80, 1'b0);
        send4(8'h33, 1'b1);
        chk("wrap_down_addr", ddram_addr, 7'h7F);
        check_rd(0);
        chk("wrap_down_rd0", rd_char, 8'h33);
        send4(8'h06, 1'b0);
        send4(8'hFF, 1'b0);
        send4(8'h34, 1'b1);
        chk("wrap_up_addr", ddram_addr, 7'h00);

        // Reset after a lone HIGH nibble, then an 8-bit byte.
        strobe(4'hC, 1'b0, 1'b0, 1'b1);
        do_reset();
        bv0 = bv_count;
        strobe(4'hC, 1'b0, 1'b0, 1'b1);
        chk("post_reset_byte", byte_data, 8'hC0);
        chk("post_reset_addr", ddram_addr, 7'h40);
        chk("post_reset_mode", mode_4bit, 0);
        chk("post_reset_bv_count", bv_count - bv0, 1);

        @(posedge clk); #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Passive receiver for the 4-bit character-LCD bus driven by the game's display driver (signals `sf_e, e, rs, rw, d, c, b, a`). It sits on the far end of that bus and does four things: samples the enable strobe, reassembles nibbles into bytes, decodes HD44780-style commands, and maintains a 2×16 shadow of display RAM. Other logic can read the shadow through a registered port. It is used on-chip as a display monitor and in the bench as the LCD-side checker for the display driver.

## Interface
Parameters:
- `CLR_CYCLES`, default 32: number of cycles the shadow-clear sequence takes. It must be ≥ 32, one shadow entry per cycle.

Ports (all bus inputs are synchronous to `clk`):
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sf_e`  in  1  bus ownership. Strobes are ignored while this is 0.
- `e`  in  1  LCD enable. The falling edge latches the bus.
- `rs`  in  1  register select: 0 = command, 1 = data.
- `rw`  in  1  1 = read cycle (not supported).
- `d`, `c`, `b`, `a`  in  1 each  LCD data DB7, DB6, DB5, DB4.
- `rd_addr`  in  5  shadow read index: 0–15 is line 1, 16–31 is line 2.
- `rd_char`  out  8  shadow character at `rd_addr`, registered.
- `byte_valid`  out  1  one-cycle pulse when a byte has been assembled.
- `byte_rs`, `byte_data`  out  1, 8  the assembled byte and its `rs`. Held until the next `byte_valid`.
- `ddram_addr`  out  7  current address counter.
- `mode_4bit`  out  1  interface width state.
- `disp_on`  out  1  display-on bit from the last on/off command.
- `busy`  out  1  high while the clear sequence runs.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- Strobe detection: `e` is registered into `e_q`. A strobe is the clock edge where `e_q`=1 and `e`=0 and `sf_e`=1.
- At a strobe, the block captures the nibble `{d,c,b,a}` and `rs` from the same edge.
- If `rw`=1 at a strobe, the strobe is discarded, `err` pulses, and the nibble phase resets to HIGH.
- 8-bit mode (the state out of reset, `mode_4bit`=0): each strobe forms a complete byte `{nib,4'h0}`.
- 4-bit mode: the byte is built from two strobes, phase HIGH then phase LOW, giving `{hi,lo}`.
  - If `rs` differs between the HIGH and LOW strobes, the byte is discarded, `err` pulses, and the phase returns to HIGH. The LOW nibble is not kept.
- Function set (byte[7:5]=001): `mode_4bit` is set to !byte[4] and the phase is set to HIGH.
- Command decode (`byte_rs`=0). If more than one line could match, the first match in this order wins:
  - 0x01 clear: `ddram_addr`=0, increment mode is set, then the clear sequence starts.
  - 0x02–0x03 home: `ddram_addr`=0.
  - 0x04–0x07 entry mode: the increment flag is set to byte[1].
  - 0x08–0x0F on/off: `disp_on` is set to byte[2].
  - 0x80–0xFF: `ddram_addr` is set to byte[6:0].
  - Any other command is ignored, but `byte_valid` still pulses.
- Data write (`byte_rs`=1):
  - Address 0x00–0x0F writes shadow entry addr[3:0].
  - Address 0x40–0x4F writes shadow entry 16+addr[3:0].
  - Any other address does not write the shadow.
  - After the write, `ddram_addr` moves ±1 (direction from the increment flag), modulo 128. So 0x7F+1 gives 0x00, and 0x00−1 gives 0x7F.
- Clear sequence: `busy`=1 and one entry per cycle (0, 1, 2, …) is written to 0x20.
  - If a data byte arrives while `busy`=1, the shadow write is dropped and `err` pulses. The address still advances.
  - Commands arriving while `busy`=1 decode normally. A second clear restarts the sequence at entry 0.

## Timing
- Reset values:
  - All shadow entries = 0x20, `rd_char`=0x20.
  - `byte_valid`=0, `byte_rs`=0, `byte_data`=0x00.
  - `ddram_addr`=0, increment flag=1, `mode_4bit`=0, `disp_on`=0, `busy`=0, `err`=0.
  - Nibble phase = HIGH, `e_q`=0.
- Assertion of `rst_n` mid-byte discards any partial nibble. There is no pulse on release.
- Latency: for a strobe at edge k, `byte_valid`, `byte_data`, `ddram_addr`, `mode_4bit`, `disp_on` and the shadow write all update at edge k+1. `rd_char` shows the new value at edge k+2.
- Clear: `busy` rises at edge k+1 and stays high for `CLR_CYCLES` cycles. Entries 0–31 are written on those cycles.
- `rd_char` is `rd_addr` registered: one-cycle latency.
- `err` and `byte_valid` are never asserted in the same cycle.
- `e` held high, or `sf_e`=0, produces no strobes and changes no state.

## Test plan
- Reset: hold `rst_n`=0 with `e` toggling. All outputs stay at their reset values; `rd_char` = 0x20 for every `rd_addr`.
- Init, 8-bit mode: strobe nibbles 3, 3, 3, 2 with `rs`=0.
  - Expect four `byte_valid` pulses with `byte_data` = 0x30, 0x30, 0x30, 0x20.
  - `mode_4bit` rises one cycle after the fourth strobe.
- 4-bit write: send 0x28, 0x0C, 0xC0, then data 0x41.
  - Expect `disp_on`=1 and `ddram_addr`=0x41.
  - Reading `rd_addr`=16 returns 0x41 two cycles after the last strobe.
- Clear: after writing 0x42 at address 0x0F, send 0x01.
  - Expect `busy` high for exactly 32 cycles, then `ddram_addr`=0 and `rd_char` = 0x20 at index 15.
  - A data byte sent during `busy` pulses `err`.
- Errors: strobe with `rw`=1 → `err` pulse, no `byte_valid`. HIGH nibble with `rs`=0 then LOW nibble with `rs`=1 → `err`, phase reset. Strobe with `sf_e`=0 → no response.
- Wrap and reset: in decrement mode at address 0x00, a data write gives `ddram_addr`=0x7F. Asserting `rst_n` after a HIGH nibble, then sending a full byte, decodes that byte correctly in 8-bit mode.
